// File: rtl/booth_mult_arbiter_if.sv
// booth_mult_arbiter_if: requester-side and multiplier-side signals of the
// shared-multiplier arbiter. The slave modport is the arbiter itself; the
// master modport is whatever drives requests and models the multiplier.
// Optional macro BOOTH_ARB_TIMEOUT_EN adds the err signal.
interface booth_mult_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int P_W   = 8
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] req_x;
    logic [N_REQ*W-1:0] req_y;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   rsp_valid;
    logic [P_W-1:0]     rsp_p;
    logic               busy;
    logic [W-1:0]       mul_x;
    logic [W-1:0]       mul_y;
    logic               mul_start;
    logic [P_W-1:0]     mul_p;
    logic               mul_done;
`ifdef BOOTH_ARB_TIMEOUT_EN
    logic               err;

    modport slave (
        input  req, req_x, req_y, mul_p, mul_done,
        output gnt, rsp_valid, rsp_p, busy, mul_x, mul_y, mul_start, err
    );
    modport master (
        output req, req_x, req_y, mul_p, mul_done,
        input  gnt, rsp_valid, rsp_p, busy, mul_x, mul_y, mul_start, err
    );
`else
    modport slave (
        input  req, req_x, req_y, mul_p, mul_done,
        output gnt, rsp_valid, rsp_p, busy, mul_x, mul_y, mul_start
    );
    modport master (
        output req, req_x, req_y, mul_p, mul_done,
        input  gnt, rsp_valid, rsp_p, busy, mul_x, mul_y, mul_start
    );
`endif
endinterface

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin sharing of one booth_mult between N_REQ
// requesters. Handles the multiplier's start-hold and done-edge timing so
// clients only see a gnt pulse and a rsp_valid pulse with the product.
// Optional macro BOOTH_ARB_TIMEOUT_EN bounds the WAIT state by TIMEOUT_CYC
// cycles and reports an expired operation on err with an all-ones product.
module booth_mult_arbiter #(
    parameter int N_REQ      = 4,
    parameter int W          = 4,
    parameter int P_W        = 8,
    parameter int START_HOLD = 3
`ifdef BOOTH_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input logic                 clk,
    input logic                 reset,
    booth_mult_arbiter_if.slave bus
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = $clog2(START_HOLD + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] pick;
    logic [HOLD_W-1:0] hold_cnt;
    logic             hold_last;
    logic             done_q;
    logic             done_edge;
`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             timed_out;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`endif

    assign hold_last = (hold_cnt == HOLD_W'(START_HOLD - 1));
    // A done level left over from the previous operation must not count,
    // so completion is the rising edge only.
    assign done_edge = bus.mul_done && !done_q;

    // Round-robin search: first asserted req at or above ptr, wrapping.
    always_comb begin
        int idx;
        pick = ptr;
        // Scan from lowest priority to highest so the last hit wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (bus.req[idx]) pick = IDX_W'(idx);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a
        // signal unassigned and no latch is inferred.
        state_nxt     = state;
        bus.gnt       = '0;
        bus.rsp_valid = '0;
        bus.busy      = (state != IDLE);
        bus.mul_start = 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
        bus.err       = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (|bus.req) state_nxt = START;
            end
            START: begin
                bus.mul_start = 1'b1;
                if (hold_cnt == '0) bus.gnt = N_REQ'(1) << winner;
                if (hold_last) state_nxt = WAIT;
            end
            WAIT: begin
                if (done_edge) state_nxt = RESP;
`ifdef BOOTH_ARB_TIMEOUT_EN
                else if (tmo_hit) state_nxt = RESP;
`endif
            end
            RESP: begin
                bus.rsp_valid = N_REQ'(1) << winner;
`ifdef BOOTH_ARB_TIMEOUT_EN
                bus.err       = timed_out;
`endif
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, winner/pointer, hold counter, done history, product.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: these are a handful of flops, not a memory array, so all
            // of them are reset to give clean outputs straight after reset.
            ptr       <= '0;
            winner    <= '0;
            hold_cnt  <= '0;
            done_q    <= 1'b0;
            bus.mul_x <= '0;
            bus.mul_y <= '0;
            bus.rsp_p <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
            timed_out <= 1'b0;
`endif
        end else begin
            done_q <= bus.mul_done;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        winner    <= pick;
                        bus.mul_x <= bus.req_x[int'(pick)*W +: W];
                        bus.mul_y <= bus.req_y[int'(pick)*W +: W];
                        hold_cnt  <= '0;
                    end
                end
                START: begin
                    if (!hold_last) hold_cnt <= hold_cnt + 1'b1;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (done_edge) bus.rsp_p <= bus.mul_p;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    else if (tmo_hit) bus.rsp_p <= '1;
                    tmo_cnt   <= tmo_cnt + 1'b1;
                    timed_out <= !done_edge && tmo_hit;
`endif
                end
                RESP: begin
                    // The winner drops to lowest priority for the next search.
                    ptr <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: table-driven vectors, hand-written corner sequences
// and randomized traffic checked against a round-robin model kept here.
// Define BOOTH_ARB_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_booth_mult_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int P_W = 8;
    localparam int SH  = 3;

    logic clk = 1'b0;
    logic reset;

    booth_mult_arbiter_if #(.N_REQ(N), .W(W), .P_W(P_W)) bus ();

    booth_mult_arbiter #(
        .N_REQ(N), .W(W), .P_W(P_W), .START_HOLD(SH)
`ifdef BOOTH_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;

    // Reference model state: pending requests, operands, round-robin pointer.
    logic [N-1:0] pending;
    logic [W-1:0] bx [N];
    logic [W-1:0] by [N];
    int           ptr_m;

    typedef struct {
        logic [N-1:0]   req_or;
        logic [N*W-1:0] xs;
        logic [N*W-1:0] ys;
        int             delay;
        bit             stuck;
        int             exp_w;
        logic [P_W-1:0] exp_p;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic logic [P_W-1:0] sprod(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        return P_W'(ia * ib);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
        if (bus.rsp_valid != '0) rsp_cnt++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_x[i*W +: W] = bx[i];
            bus.req_y[i*W +: W] = by[i];
        end
        bus.req = pending;
    endtask

    // One complete operation; requests must already be driven in an IDLE cycle.
    task automatic run_op(input int exp_w, input logic [P_W-1:0] exp_p,
                          input int delay, input bit stuck, input string tag);
        int n;
        int rc;
        rc = rsp_cnt;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.gnt == '0 && n < 40);
        check({tag, "_gnt"}, bus.gnt, oh(exp_w));
        check({tag, "_ops"}, {bus.mul_x, bus.mul_y}, {bx[exp_w], by[exp_w]});
        pending[exp_w] = 1'b0;
        drive();
        if (!stuck) bus.mul_done = 1'b0;
        n = 0;
        while (bus.mul_start && n < 20) begin
            n++;
            step();
        end
        check({tag, "_start_len"}, n, SH);
        if (stuck) begin
            repeat (3) step();
            bus.mul_done = 1'b0;
            step();
        end
        repeat (delay) step();
        check({tag, "_early_rsp"}, rsp_cnt - rc, 0);
        bus.mul_p    = sprod(bus.mul_x, bus.mul_y);
        bus.mul_done = 1'b1;
        step();
        check({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_p, bus.busy}, {oh(exp_w), exp_p, 1'b1});
        check({tag, "_ops_hold"}, {bus.mul_x, bus.mul_y}, {bx[exp_w], by[exp_w]});
`ifdef BOOTH_ARB_TIMEOUT_EN
        check({tag, "_err"}, bus.err, 0);
`endif
        step();
        check({tag, "_idle"}, {bus.busy, bus.gnt, bus.rsp_valid, bus.rsp_p},
              {1'b0, {N{1'b0}}, {N{1'b0}}, exp_p});
        ptr_m = (exp_w + 1) % N;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rc;
        int w;
        logic [N-1:0] add;
        int order [5] = '{0, 1, 2, 3, 0};

        tbl[0] = '{4'b0100, 16'h0300, 16'h0500, 8, 1'b0, 2, 8'h0F};
        tbl[1] = '{4'b0011, 16'h007E, 16'h0073, 2, 1'b0, 0, 8'hFA};
        tbl[2] = '{4'b1000, 16'h8000, 16'h8000, 0, 1'b0, 1, 8'h31};
        tbl[3] = '{4'b0000, 16'h0000, 16'h0000, 5, 1'b1, 3, 8'h40};
        tbl[4] = '{4'b1001, 16'h000F, 16'h5001, 1, 1'b0, 0, 8'hFF};
        tbl[5] = '{4'b0000, 16'h0000, 16'h0000, 3, 1'b0, 3, 8'h00};

        reset        = 1'b0;
        pending      = '0;
        ptr_m        = 0;
        bus.mul_p    = '0;
        bus.mul_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            bx[i] = '0;
            by[i] = '0;
        end
        drive();
        step();
        step();
        check("reset_state", {bus.gnt, bus.rsp_valid, bus.rsp_p, bus.busy,
                              bus.mul_x, bus.mul_y, bus.mul_start}, 0);
        reset = 1'b1;
        step();

        // Table-driven operations.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                if (tbl[t].req_or[i]) begin
                    bx[i] = tbl[t].xs[i*W +: W];
                    by[i] = tbl[t].ys[i*W +: W];
                end
            end
            pending = pending | tbl[t].req_or;
            drive();
            run_op(tbl[t].exp_w, tbl[t].exp_p, tbl[t].delay, tbl[t].stuck,
                   $sformatf("tbl%0d", t));
        end

        // Reset during WAIT discards the operation and clears the pointer.
        pending = 4'b0010; bx[1] = 4'd3; by[1] = 4'hD;
        drive();
        run_op(1, 8'hF7, 2, 1'b0, "pre_rst");
        pending = 4'b0100; bx[2] = 4'd6; by[2] = 4'd2;
        drive();
        n = 0;
        do begin
            step();
            n++;
        end while (bus.gnt == '0 && n < 40);
        check("rst_op_gnt", bus.gnt, 4'b0100);
        pending = '0;
        bus.mul_done = 1'b0;
        drive();
        repeat (SH + 1) step();
        check("rst_in_wait", {bus.busy, bus.mul_start}, 2'b10);
        pending = 4'b0001; bx[0] = 4'd5; by[0] = 4'd5;
        drive();
        rc = rsp_cnt;
        reset = 1'b0;
        step();
        check("rst_outs", {bus.gnt, bus.rsp_valid, bus.rsp_p, bus.busy,
                           bus.mul_x, bus.mul_y, bus.mul_start}, 0);
        bus.mul_done = 1'b1;
        step();
        reset = 1'b1;
        bus.mul_done = 1'b0;
        ptr_m = 0;
        check("rst_no_rsp", rsp_cnt - rc, 0);
        pending[3] = 1'b1; bx[3] = 4'd1; by[3] = 4'd2;
        drive();
        run_op(0, 8'h19, 1, 1'b0, "post_rst");
        run_op(3, 8'h02, 0, 1'b0, "post_rst2");

        // Requester 1 withdraws before it is granted.
        pending = 4'b1011;
        bx[0] = 4'd4; by[0] = 4'd4;
        bx[1] = 4'd1; by[1] = 4'd1;
        bx[3] = 4'd2; by[3] = 4'd3;
        drive();
        run_op(0, 8'h10, 3, 1'b0, "drop_a");
        pending[1] = 1'b0;
        drive();
        run_op(3, 8'h06, 1, 1'b0, "drop_b");
        repeat (3) begin
            step();
            check("drop_quiet", {bus.gnt, bus.busy}, 0);
        end

        // All four requesting continuously from reset.
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        ptr_m = 0;
        pending = 4'b1111;
        for (int i = 0; i < N; i++) begin
            bx[i] = W'($urandom);
            by[i] = W'($urandom);
        end
        drive();
        for (int j = 0; j < 5; j++) begin
            w = order[j];
            run_op(w, sprod(bx[w], by[w]), int'($urandom_range(0, 4)), 1'b0,
                   $sformatf("rr%0d", j));
            pending[w] = 1'b1;
            bx[w] = W'($urandom);
            by[w] = W'($urandom);
            drive();
        end

        // Randomized traffic against the round-robin model.
        for (int r = 0; r < 30; r++) begin
            add = N'($urandom_range(0, (1 << N) - 1)) & ~pending;
            if ((pending | add) == '0) add = oh(int'($urandom_range(0, N - 1)));
            for (int i = 0; i < N; i++) begin
                if (add[i]) begin
                    bx[i] = W'($urandom);
                    by[i] = W'($urandom);
                end
            end
            pending = pending | add;
            drive();
            w = rr_pick(pending, ptr_m);
            run_op(w, sprod(bx[w], by[w]), int'($urandom_range(0, 6)),
                   $urandom_range(0, 3) == 0, $sformatf("rnd%0d", r));
        end

`ifdef BOOTH_ARB_TIMEOUT_EN
        // Done never arrives: RESP after 16 WAIT cycles with all-ones product.
        if (pending == '0) begin
            pending[2] = 1'b1; bx[2] = 4'd3; by[2] = 4'd3;
        end
        drive();
        w = rr_pick(pending, ptr_m);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.gnt == '0 && n < 40);
        check("to_gnt", bus.gnt, oh(w));
        pending[w] = 1'b0;
        drive();
        bus.mul_done = 1'b0;
        n = 0;
        while (bus.mul_start && n < 20) begin
            n++;
            step();
        end
        n = 1;
        while (bus.rsp_valid == '0 && n < 60) begin
            step();
            n++;
        end
        check("to_cycle", n, 17);
        check("to_rsp", {bus.rsp_valid, bus.rsp_p, bus.err}, {oh(w), 8'hFF, 1'b1});
        step();
        check("to_err_clear", bus.err, 0);
        ptr_m = (w + 1) % N;
        if (pending == '0) begin
            pending[(w + 1) % N] = 1'b1;
            bx[(w + 1) % N] = 4'd2;
            by[(w + 1) % N] = 4'd7;
        end
        drive();
        w = rr_pick(pending, ptr_m);
        run_op(w, sprod(bx[w], by[w]), 2, 1'b0, "to_next");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
Shares one booth_mult instance between N_REQ independent requesters. Each requester presents an operand pair and a request. The block picks requesters round-robin, drives the multiplier's start/done handshake, and returns the product to the granted requester. It sits between the client blocks and a single booth_mult, so the multiplier's start-hold and done timing are handled in one place.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 4, operand width per x/y
P_W, 8, product width returned by the multiplier
START_HOLD, 3, cycles mul_start is held high per operation (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on the next clk edge)
req  in  N_REQ  per-requester request, level, held until gnt
req_x  in  N_REQ*W  packed x operands, requester i at [i*W +: W]
req_y  in  N_REQ*W  packed y operands, same packing
gnt  out  N_REQ  one-hot, one-cycle pulse: operands accepted
rsp_valid  out  N_REQ  one-hot, one-cycle pulse: product ready for that requester
rsp_p  out  P_W  product, valid only while rsp_valid!=0
busy  out  1  high in every state except IDLE
mul_x  out  W  multiplier x operand, registered
mul_y  out  W  multiplier y operand, registered
mul_start  out  1  multiplier start
mul_p  in  P_W  multiplier product
mul_done  in  1  multiplier done (level)

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_p=0, busy=0, mul_x=0, mul_y=0, mul_start=0. Round-robin pointer=0, so requester 0 has top priority first. FSM=IDLE, done_q=0.
- Reset mid-operation: the operation in flight is discarded with no rsp_valid. mul_start drops on the reset edge.
- FSM states: IDLE -> START -> WAIT -> RESP -> IDLE.
- IDLE:
  - If req!=0, grant the first asserted requester, searching upward from ptr and wrapping N_REQ-1 -> 0.
  - On that edge: latch mul_x/mul_y from the winner's slice, store the winner index, pulse gnt[winner] for the next cycle, go to START.
  - If req==0, stay in IDLE.
- START:
  - mul_start=1 for exactly START_HOLD cycles, counted by a hold counter, then go to WAIT.
  - mul_x/mul_y stay stable from START through RESP.
- WAIT:
  - mul_start=0. done_q registers mul_done every cycle in all states.
  - Completion is mul_done==1 && done_q==0 (rising edge) seen in WAIT. A done level left high from the previous operation is ignored.
  - On completion: capture mul_p into rsp_p and go to RESP.
- RESP:
  - rsp_valid[winner]=1 for one cycle.
  - ptr <= (winner+1) mod N_REQ, then go to IDLE.
  - rsp_p holds its value until the next capture.
- Latency:
  - req seen in IDLE at edge k gives gnt high during cycle k+1 and mul_start high in cycles k+1..k+START_HOLD.
  - rsp_valid is high the cycle after the done edge.
- Requester rules:
  - Requesters hold req and operands stable until gnt. Dropping req before gnt withdraws the request without error.
  - Operands are sampled only at grant, so the requester may change them after gnt.
- Simultaneous events:
  - A winner re-asserting req in the RESP cycle is considered in the next IDLE, at the lowest priority.
  - The new grant happens no earlier than the cycle after RESP; there are no back-to-back overlapping operations.
- Signed operands pass through unchanged; the block does no arithmetic on x/y/p.
- At most one gnt bit and one rsp_valid bit are high in any cycle.

Optional Feature:
Macro BOOTH_ARB_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 64) and output err (1 bit, reset 0).
  - A counter runs in WAIT. If no done edge arrives within TIMEOUT_CYC cycles, go to RESP with rsp_p = all-ones, and err=1 for that RESP cycle only.
  - The pointer advances as normal.
- Undefined: WAIT is unbounded, and the err port and counter do not exist.

Test Plan:
- Reset held low 2 cycles during WAIT with req=4'b0001 -> no rsp_valid; all outputs 0 on the cycle after the reset edge; first grant after release goes to requester 0.
- Single request, req=4'b0100, x2=4'd3, y2=4'd5, model done 8 cycles after start falls with p=8'd15 -> gnt=4'b0100 one cycle; mul_start high exactly 3 cycles; rsp_valid=4'b0100 with rsp_p=15.
- All four requesting continuously from reset -> grant order 0,1,2,3,0; never two operations in flight.
- mul_done stuck high from the previous op when the next op starts -> no completion until done falls and rises again.
- Requester 1 drops req before its grant while requester 3 is asserted -> requester 3 is granted; requester 1 gets no gnt or rsp.
- BOOTH_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, done never asserts -> rsp_valid on cycle 17 of WAIT with rsp_p=8'hFF, err=1 for one cycle; the next requester is served normally.
